// File: rtl/fp_pkg.sv
// Shared constants and types for the floating-point datapath blocks.
package fp_pkg;

   localparam int EXP_W_DEF = 8;
   localparam int MAN_W_DEF = 23;

   localparam int FLG_INV = 3;
   localparam int FLG_OVF = 2;
   localparam int FLG_UDF = 1;
   localparam int FLG_INX = 0;

   typedef enum logic [2:0] {ZERO, NORM, INF, QNAN, SNAN} fp_class_e;

   // Canonical quiet NaN right-aligned in 64 bits; callers truncate to their width.
   function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
      logic [63:0] r;
      r = '0;
      for (int i = 0; i < exp_w; i++) r[man_w+i] = 1'b1;
      r[man_w-1] = 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/fp_lzc.sv
// Parametrised leading-zero counter; cnt is 0 when the input is all zero.
module fp_lzc #(
   parameter  int WIDTH = 28,
   localparam int CNT_W = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] din,
   output logic [CNT_W-1:0] cnt,
   output logic             all_zero
);

   // Scan upward so the highest set bit wins.
   always_comb begin
      cnt = '0;
      for (int i = 0; i < WIDTH; i++)
         if (din[i]) cnt = CNT_W'(WIDTH - 1 - i);
   end

   assign all_zero = ~|din;

endmodule

// File: rtl/fp_add_pipe.sv
// 3-stage IEEE-754 add/sub (FTZ, RNE) with valid/ready handshake and exception flags.
module fp_add_pipe
   import fp_pkg::*;
#(
   parameter  int EXP_W = EXP_W_DEF,
   parameter  int MAN_W = MAN_W_DEF,
   localparam int W     = EXP_W + MAN_W + 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         op_sub,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] result,
   output logic [3:0]   flags
);

   localparam int STAGES = 3;
   localparam int SIG_W  = MAN_W + 4;   // hidden, fraction, guard, round, sticky
   localparam int SW     = MAN_W + 5;   // sum with carry bit
   localparam int LZW    = $clog2(SW);
   localparam int EW2    = EXP_W + 2;
   localparam int RW     = MAN_W + 2;
   localparam logic [W-1:0]   CANON_NAN = W'(fp_qnan(EXP_W, MAN_W));
   localparam logic [EW2-1:0] EMAX      = EW2'((1 << EXP_W) - 1);

   function automatic fp_class_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
      if (e == '0) return ZERO;
      if (e != '1) return NORM;
      if (f == '0) return INF;
      return f[MAN_W-1] ? QNAN : SNAN;
   endfunction

   logic [STAGES:1] vld_pipe;
   logic            en;

   assign en        = out_ready | ~vld_pipe[STAGES];
   assign in_ready  = en;
   assign out_valid = vld_pipe[STAGES];

   // ---------------- S1: decode, classify, swap, align ----------------
   logic [W-1:0]       bx;
   logic               sa, sb;
   logic [EXP_W-1:0]   ea, eb, diff;
   logic [MAN_W-1:0]   fa_m, fb_m;
   fp_class_e          ca, cb;
   logic               swap;
   logic [SIG_W-1:0]   sig_big, sig_sml, sig_sh;
   logic [2*SIG_W-1:0] wide;
   logic               spec_d;
   logic [W-1:0]       spec_res_d;
   logic [3:0]         spec_flg_d;

   assign bx   = {b[W-1] ^ op_sub, b[W-2:0]};
   assign sa   = a[W-1];
   assign sb   = bx[W-1];
   assign ea   = a[W-2:MAN_W];
   assign eb   = bx[W-2:MAN_W];
   assign ca   = classify(ea, a[MAN_W-1:0]);
   assign cb   = classify(eb, bx[MAN_W-1:0]);
   assign fa_m = (ca == ZERO) ? '0 : a[MAN_W-1:0];
   assign fb_m = (cb == ZERO) ? '0 : bx[MAN_W-1:0];

   assign swap    = {eb, fb_m} > {ea, fa_m};
   assign diff    = swap ? (eb - ea) : (ea - eb);
   assign sig_big = swap ? {cb != ZERO, fb_m, 3'b000} : {ca != ZERO, fa_m, 3'b000};
   assign sig_sml = swap ? {ca != ZERO, fa_m, 3'b000} : {cb != ZERO, fb_m, 3'b000};
   assign wide    = {sig_sml, {SIG_W{1'b0}}} >> diff;

   always_comb begin
      if (int'(diff) >= MAN_W + 3) sig_sh = {{(SIG_W-1){1'b0}}, |sig_sml};
      else                         sig_sh = {wide[2*SIG_W-1:SIG_W+1], |wide[SIG_W:0]};
   end

   always_comb begin
      spec_d     = 1'b0;
      spec_res_d = '0;
      spec_flg_d = '0;
      if (ca == QNAN || ca == SNAN || cb == QNAN || cb == SNAN) begin
         spec_d              = 1'b1;
         spec_res_d          = CANON_NAN;
         spec_flg_d[FLG_INV] = (ca == SNAN) || (cb == SNAN);
      end else if (ca == INF && cb == INF && sa != sb) begin
         spec_d              = 1'b1;
         spec_res_d          = CANON_NAN;
         spec_flg_d[FLG_INV] = 1'b1;
      end else if (ca == INF) begin
         spec_d     = 1'b1;
         spec_res_d = a;
      end else if (cb == INF) begin
         spec_d     = 1'b1;
         spec_res_d = bx;
      end
   end

   logic             s1_sign, s1_sub, s1_spec;
   logic [EXP_W-1:0] s1_exp;
   logic [SIG_W-1:0] s1_sig_b, s1_sig_s;
   logic [W-1:0]     s1_spec_res;
   logic [3:0]       s1_spec_flg;

   // ---------------- S2: add/sub, leading-zero count ----------------
   logic [SW-1:0]  sum;
   logic [LZW-1:0] lzc;
   logic           sum_zero;

   assign sum = s1_sub ? ({1'b0, s1_sig_b} - {1'b0, s1_sig_s})
                       : ({1'b0, s1_sig_b} + {1'b0, s1_sig_s});

   fp_lzc #(.WIDTH(SW)) u_lzc (.din(sum), .cnt(lzc), .all_zero(sum_zero));

   logic             s2_sign, s2_zero, s2_spec;
   logic [EXP_W-1:0] s2_exp;
   logic [SW-1:0]    s2_sum;
   logic [LZW-1:0]   s2_lzc;
   logic [W-1:0]     s2_spec_res;
   logic [3:0]       s2_spec_flg;

   // ---------------- S3: normalise, round, pack ----------------
   logic [SIG_W-1:0] mant;
   logic [EW2-1:0]   e_n, e_r;
   logic [RW-1:0]    rnd;
   logic [MAN_W-1:0] frac_r;
   logic             up;
   logic [W-1:0]     res_d;
   logic [3:0]       flg_d;

   // Hidden bit sits one below the carry bit, so a normalised no-carry sum has lzc=1.
   always_comb begin
      if (s2_sum[SW-1]) begin
         mant = {s2_sum[SW-1:2], s2_sum[1] | s2_sum[0]};
         e_n  = {2'b00, s2_exp} + EW2'(1);
      end else begin
         mant = s2_sum[SW-2:0] << (s2_lzc - LZW'(1));
         e_n  = {2'b00, s2_exp} + EW2'(1) - EW2'(s2_lzc);
      end
      up  = mant[2] & (mant[1] | mant[0] | mant[3]);
      rnd = {1'b0, mant[SIG_W-1:3]} + RW'(up);
      if (rnd[RW-1]) begin
         e_r    = e_n + EW2'(1);
         frac_r = rnd[MAN_W:1];
      end else begin
         e_r    = e_n;
         frac_r = rnd[MAN_W-1:0];
      end
   end

   always_comb begin
      res_d = '0;
      flg_d = '0;
      if (s2_spec) begin
         res_d = s2_spec_res;
         flg_d = s2_spec_flg;
      end else if (s2_zero) begin
         res_d = {s2_sign, {(W-1){1'b0}}};
      end else if (e_r[EW2-1] || e_r == '0) begin
         res_d          = {s2_sign, {(W-1){1'b0}}};
         flg_d[FLG_UDF] = 1'b1;
         flg_d[FLG_INX] = 1'b1;
      end else if (e_r >= EMAX) begin
         res_d          = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         flg_d[FLG_OVF] = 1'b1;
         flg_d[FLG_INX] = 1'b1;
      end else begin
         res_d          = {s2_sign, e_r[EXP_W-1:0], frac_r};
         flg_d[FLG_INX] = |mant[2:0];
      end
   end

   // A stall freezes every stage, so one enable serves the whole pipe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_pipe    <= '0;
         s1_sign     <= 1'b0;
         s1_sub      <= 1'b0;
         s1_spec     <= 1'b0;
         s1_exp      <= '0;
         s1_sig_b    <= '0;
         s1_sig_s    <= '0;
         s1_spec_res <= '0;
         s1_spec_flg <= '0;
         s2_sign     <= 1'b0;
         s2_zero     <= 1'b0;
         s2_spec     <= 1'b0;
         s2_exp      <= '0;
         s2_sum      <= '0;
         s2_lzc      <= '0;
         s2_spec_res <= '0;
         s2_spec_flg <= '0;
         result      <= '0;
         flags       <= '0;
      end else if (en) begin
         vld_pipe    <= {vld_pipe[STAGES-1:1], in_valid};
         s1_sign     <= swap ? sb : sa;
         s1_sub      <= sa ^ sb;
         s1_spec     <= spec_d;
         s1_exp      <= swap ? eb : ea;
         s1_sig_b    <= sig_big;
         s1_sig_s    <= sig_sh;
         s1_spec_res <= spec_res_d;
         s1_spec_flg <= spec_flg_d;
         s2_sign     <= (sum_zero & s1_sub) ? 1'b0 : s1_sign;
         s2_zero     <= sum_zero;
         s2_spec     <= s1_spec;
         s2_exp      <= s1_exp;
         s2_sum      <= sum;
         s2_lzc      <= lzc;
         s2_spec_res <= s1_spec_res;
         s2_spec_flg <= s1_spec_flg;
         result      <= res_d;
         flags       <= flg_d;
      end
   end

endmodule

// File: doc/fp_add_pipe.md
Name: fp_add_pipe

Overview:
- Parametrised, pipelined IEEE-754 adder/subtractor; next generation of the single-cycle float adder feeding the MAC datapath.
- Generic exponent/fraction widths. Correct sign handling for subtraction, round-to-nearest-even, special-value handling and exception flags.
- Valid/ready streaming interface, 3-stage pipeline, one result per cycle when not stalled.

Parameters:
- EXP_W, 8, exponent field width (bias = 2^(EXP_W-1)-1).
- MAN_W, 23, stored fraction width (hidden bit implicit).
- W, EXP_W+MAN_W+1, total operand width (derived, not overridable).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands/op presented.
- in_ready  out  1  stage-1 can accept this cycle.
- a  in  W  operand A.
- b  in  W  operand B.
- op_sub  in  1  1: A-B (B sign inverted before processing), 0: A+B.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- result  out  W  packed IEEE result.
- flags  out  4  {invalid, overflow, underflow, inexact}, aligned with result.

Behaviour:
- Reset (async assert, sync-safe release): all stage valid bits 0; out_valid=0, result=0, flags=0; in_ready=1 after release. Reset mid-operation discards all in-flight items, with no partial outputs.
- Pipeline enable: en = out_ready | ~out_valid_s3. Bubbles are not compressed, so a stall freezes all stages. in_ready = en (combinational).
- Transfer occurs on in_valid & in_ready. Latency is exactly 3 enabled cycles from input transfer to out_valid. Throughput is 1/cycle with out_ready held high.
- While out_valid=1 and out_ready=0, result and flags hold stable.
- S1 (align):
  - Decode operands; subnormal inputs are flushed to signed zero (FTZ).
  - Classify zero/inf/NaN.
  - Swap so that |big| >= |small|, comparing {exp,frac}, not exponent only.
  - Right-shift the small significand by the exponent difference into MAN_W+4 bits: hidden bit, fraction, guard, round, sticky. If the shift is >= MAN_W+3, the significand becomes sticky only.
- S2 (add):
  - Effective op = sign_big XOR sign_small'. Add or subtract significands in MAN_W+5 bits.
  - Leading-zero count of the sum via fp_lzc.
  - Result sign = sign_big.
  - Exact zero difference gives +0. -0 + -0 gives -0.
- S3 (normalise/round/pack):
  - Carry out: shift right 1 and exp+1, OR-ing the dropped bit into sticky.
  - Otherwise shift left by lzc and exp-lzc.
  - Round-to-nearest-even on guard/round/sticky. Rounding carry renormalises.
  - inexact = any of G|R|S nonzero.
  - exp >= all-ones: +/-inf, overflow=1, inexact=1.
  - exp <= 0 (or lzc exceeds exp): signed zero, underflow=1, inexact=1 (FTZ output).
- Specials, which override the arithmetic path:
  - Any NaN input: canonical qNaN (sign 0, exp all ones, frac MSB 1, rest 0). invalid=1 only for signalling NaN.
  - inf + (-inf) after op_sub adjustment: qNaN, invalid=1.
  - Single inf: that inf, no flags.
  - x + 0: x exactly.

Decomposition:
- Shared package fp_pkg holds:
  - Default EXP_W/MAN_W constants.
  - Flag bit indices: FLG_INV=3, FLG_OVF=2, FLG_UDF=1, FLG_INX=0.
  - Class encoding typedef (ZERO, NORM, INF, QNAN, SNAN).
  - Function returning the canonical qNaN for given widths.
- One sub-module: fp_lzc, a parametrised leading-zero counter (width MAN_W+5, output clog2 width, all-zero flag). It is reused later by the multiplier normaliser.

Test Plan:
- 3F800000 + 40000000, op_sub=0 -> 40400000 after 3 cycles, flags=0. Then 3F800000 - 3F800000 (op_sub=1) -> 00000000, flags=0.
- Rounding:
  - 3F800000 + 33800000 (tie) -> 3F800000, inexact=1.
  - 3F800000 + 33800001 -> 3F800001, inexact=1.
  - 3F800001 + 33800000 -> 3F800002 (round to even).
- 7F7FFFFF + 7F7FFFFF -> 7F800000, overflow=1, inexact=1. 7F800000 + FF800000 -> 7FC00000, invalid=1. 7FA00000 + 3F800000 -> 7FC00000, invalid=1.
- Cancellation: 3F800001 - 3F800000 -> 34000000, flags=0. C0400000 + 40000000 -> BF800000 (sign from larger magnitude).
- Backpressure: stream 5 back-to-back adds, drop out_ready for 4 cycles after the first result -> in_ready=0 during the stall, result held stable, all 5 results emerge in order with no loss or duplication.
- Assert rst with 2 items in flight -> out_valid drops immediately. After release, no stale result appears and the next input completes with 3-cycle latency.
